// File: rtl/paddle_move_sched.sv
// paddle_move_sched: two-paddle movement scheduler.
// Raw buttons are synchronized and debounced. A per-paddle FSM tracks which
// direction is held. One step pulse is issued per unpaused frameTick.
// Optional acceleration (second pulse per frame after a long hold) is
// compiled in only when macro PADDLE_ACCEL_EN is defined.
//
// state      | meaning
// -----------+------------------------------------------------
// ST_IDLE    | no button held, or both held (conflict)
// ST_MOVE_UP | only the up button is held (debounced)
// ST_MOVE_DN | only the down button is held (debounced)
module paddle_move_sched #(
   parameter int DEBOUNCE_CYCLES = 1000000,
   parameter int ACCEL_FRAMES    = 30
) (
   input  logic       CLK_100MHz,
   input  logic       Reset,
   input  logic [1:0] btnUp,
   input  logic [1:0] btnDown,
   input  logic       frameTick,
   input  logic       pause,
   output logic [1:0] moveUp,
   output logic [1:0] moveDown
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_MOVE_UP = 2'd1,
      ST_MOVE_DN = 2'd2
   } t_state;

   if (DEBOUNCE_CYCLES < 1 || ACCEL_FRAMES < 1) begin : g_param_check
      $error("paddle_move_sched: DEBOUNCE_CYCLES and ACCEL_FRAMES must be >= 1");
   end

   // bit order for the button vectors: [1:0] up buttons, [3:2] down buttons
   logic [3:0]    w_raw;
   logic [3:0]    r_sync1;
   logic [3:0]    r_sync2;
   logic [3:0]    r_deb;
   logic [CW-1:0] r_db_cnt [4];

   t_state        r_state     [2];
   t_state        w_state_nxt [2];
   logic [1:0]    w_keep;
   logic [1:0]    w_up_nxt;
   logic [1:0]    w_dn_nxt;

   assign w_raw = {btnDown, btnUp};

   // two-flop synchronizer on every raw button bit
   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
      end
   end

   // per-bit debounce: accept a new value after DEBOUNCE_CYCLES consecutive differing cycles
   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         r_deb <= '0;
         for (int k = 0; k < 4; k++) r_db_cnt[k] <= '0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (r_sync2[k] == r_deb[k]) begin
               r_db_cnt[k] <= '0;
            end else if (r_db_cnt[k] == DB_LAST) begin
               r_deb[k]    <= r_sync2[k];
               r_db_cnt[k] <= '0;
            end else begin
               r_db_cnt[k] <= r_db_cnt[k] + CW'(1);
            end
         end
      end
   end

   // FSM state register, one per paddle
   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         for (int p = 0; p < 2; p++) r_state[p] <= ST_IDLE;
      end else begin
         for (int p = 0; p < 2; p++) r_state[p] <= w_state_nxt[p];
      end
   end

   // FSM next state straight from the debounced buttons; both held is a conflict
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         w_state_nxt[p] = ST_IDLE;
         case ({r_deb[p], r_deb[2+p]})
            2'b10:   w_state_nxt[p] = ST_MOVE_UP;
            2'b01:   w_state_nxt[p] = ST_MOVE_DN;
            default: w_state_nxt[p] = ST_IDLE;
         endcase
      end
   end

`ifdef PADDLE_ACCEL_EN
   localparam int HW = $clog2(ACCEL_FRAMES + 1);
   localparam logic [HW-1:0] HOLD_MAX = HW'(ACCEL_FRAMES);

   logic [HW-1:0] r_hold [2];
   // 2 = armed on the tick, 1 = fire the second pulse this cycle, 0 = none
   logic [1:0]    r_pend [2];

   // hold counter and second-pulse scheduling; any state change, pause or new tick cancels
   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         for (int p = 0; p < 2; p++) begin
            r_hold[p] <= '0;
            r_pend[p] <= '0;
         end
      end else begin
         for (int p = 0; p < 2; p++) begin
            if (!w_keep[p]) begin
               r_hold[p] <= '0;
               r_pend[p] <= '0;
            end else if (frameTick && !pause) begin
               r_pend[p] <= '0;
               if (r_state[p] != ST_IDLE) begin
                  if (r_hold[p] == HOLD_MAX) r_pend[p] <= 2'd2;
                  else                       r_hold[p] <= r_hold[p] + HW'(1);
               end
            end else if (frameTick || pause) begin
               r_pend[p] <= '0;
            end else if (r_pend[p] != 2'd0) begin
               r_pend[p] <= r_pend[p] - 2'd1;
            end
         end
      end
   end
`endif

   // output decision: pulse only if the state registered on the tick cycle is kept
   always_comb begin
      w_keep   = '0;
      w_up_nxt = '0;
      w_dn_nxt = '0;
      for (int p = 0; p < 2; p++) begin
         w_keep[p] = (w_state_nxt[p] == r_state[p]);
         if (frameTick && !pause && w_keep[p]) begin
            w_up_nxt[p] = (r_state[p] == ST_MOVE_UP);
            w_dn_nxt[p] = (r_state[p] == ST_MOVE_DN);
         end
`ifdef PADDLE_ACCEL_EN
         if (r_pend[p] == 2'd1 && !frameTick && !pause && w_keep[p]) begin
            w_up_nxt[p] = (r_state[p] == ST_MOVE_UP);
            w_dn_nxt[p] = (r_state[p] == ST_MOVE_DN);
         end
`endif
      end
   end

   // registered step pulses
   always_ff @(posedge CLK_100MHz) begin
      if (Reset) begin
         moveUp   <= '0;
         moveDown <= '0;
      end else begin
         moveUp   <= w_up_nxt;
         moveDown <= w_dn_nxt;
      end
   end

endmodule

// File: tb/tb_paddle_move_sched.sv
// Bench for paddle_move_sched with DEBOUNCE_CYCLES=4, ACCEL_FRAMES=3.
// Each driven cycle pushes the expected {moveUp, moveDown}; the value is
// popped and compared just after the clock edge that registers it.
module tb_paddle_move_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] b_up;
   logic [1:0] b_dn;
   logic       ft;
   logic       ps;
   logic [1:0] move_up;
   logic [1:0] move_dn;

   int n_total = 0;
   int n_bad   = 0;

   logic [3:0] q_exp [$];
   string      q_tag [$];

`ifdef PADDLE_ACCEL_EN
   localparam logic [1:0] ACC2 = 2'b01;
`else
   localparam logic [1:0] ACC2 = 2'b00;
`endif

   paddle_move_sched #(
      .DEBOUNCE_CYCLES(4),
      .ACCEL_FRAMES   (3)
   ) u_dut (
      .CLK_100MHz(clk),
      .Reset     (rst),
      .btnUp     (b_up),
      .btnDown   (b_dn),
      .frameTick (ft),
      .pause     (ps),
      .moveUp    (move_up),
      .moveDown  (move_dn)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: {up,dn} got %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   // one clock cycle: drive frameTick, queue the expectation, compare after the edge
   task automatic step(input logic tick, input logic [1:0] eu, input logic [1:0] ed,
                       input string tag);
      logic [3:0] e;
      string      t;
      ft = tick;
      q_exp.push_back({eu, ed});
      q_tag.push_back(tag);
      @(posedge clk);
      #1;
      ft = 1'b0;
      e = q_exp.pop_front();
      t = q_tag.pop_front();
      chk(t, {move_up, move_dn}, e);
   endtask

   task automatic idle(input int n, input string tag);
      for (int i = 0; i < n; i++) step(1'b0, 2'b00, 2'b00, tag);
   endtask

   initial begin
      rst  = 1'b1;
      b_up = 2'b00;
      b_dn = 2'b00;
      ft   = 1'b0;
      ps   = 1'b0;

      // reset state
      step(1'b0, 2'b00, 2'b00, "reset0");
      step(1'b1, 2'b00, 2'b00, "reset_tick");
      rst = 1'b0;
      idle(4, "post_reset");

      // up on paddle 0: single pulse on the cycle after the tick only
      b_up = 2'b01;
      idle(10, "up0_settle");
      step(1'b1, 2'b01, 2'b00, "up0_pulse");
      idle(3, "up0_after");
      b_up = 2'b00;
      idle(10, "up0_release");

      // 2-cycle glitch on down[1] never passes debounce
      b_dn = 2'b10;
      idle(2, "glitch_hi");
      b_dn = 2'b00;
      idle(8, "glitch_lo");
      step(1'b1, 2'b00, 2'b00, "glitch_tick");
      idle(2, "glitch_after");

      // conflict on paddle 0, then release down
      b_up = 2'b01;
      b_dn = 2'b01;
      idle(10, "conf_settle");
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'b00, 2'b00, "conf_tick");
         idle(2, "conf_gap");
      end
      b_dn = 2'b00;
      idle(8, "conf_release");
      step(1'b1, 2'b01, 2'b00, "conf_resolved");
      b_up = 2'b00;
      idle(10, "conf_clear");

      // pause suppresses ticks, debounce keeps running
      ps   = 1'b1;
      b_up = 2'b10;
      idle(10, "pause_settle");
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 2'b00, 2'b00, "pause_tick");
         idle(2, "pause_gap");
      end
      ps = 1'b0;
      idle(1, "unpause");
      step(1'b1, 2'b10, 2'b00, "unpause_pulse");
      b_up = 2'b00;
      idle(10, "pause_clear");

      // both paddles serviced on the same tick
      b_up = 2'b01;
      b_dn = 2'b10;
      idle(10, "both_settle");
      step(1'b1, 2'b01, 2'b10, "both_pulse");
      idle(2, "both_after");
      b_up = 2'b00;
      b_dn = 2'b00;
      idle(10, "both_clear");

      // reset on the tick cycle, then a full debounce is needed again
      b_dn = 2'b01;
      idle(10, "rst_settle");
      rst = 1'b1;
      step(1'b1, 2'b00, 2'b00, "rst_on_tick");
      rst = 1'b0;
      idle(2, "rst_wait");
      step(1'b1, 2'b00, 2'b00, "rst_early_tick");
      idle(3, "rst_wait2");
      step(1'b1, 2'b00, 2'b00, "rst_state_change_tick");
      step(1'b1, 2'b00, 2'b01, "rst_redebounced");
      b_dn = 2'b00;
      idle(10, "rst_clear");

      // long hold: single pulses for ticks 1-3, second pulse from tick 4
      b_up = 2'b01;
      idle(10, "acc_settle");
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 2'b01, 2'b00, "acc_early");
         idle(3, "acc_early_gap");
      end
      step(1'b1, 2'b01, 2'b00, "acc_t4_first");
      step(1'b0, 2'b00, 2'b00, "acc_t4_gap");
      step(1'b0, ACC2,  2'b00, "acc_t4_second");
      idle(3, "acc_t4_after");
      step(1'b1, 2'b01, 2'b00, "acc_t5_first");
      ps = 1'b1;
      step(1'b0, 2'b00, 2'b00, "acc_cancel_gap");
      step(1'b0, 2'b00, 2'b00, "acc_cancel_second");
      ps = 1'b0;
      idle(3, "acc_cancel_after");
      b_up = 2'b00;
      idle(10, "acc_clear");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/paddle_move_sched.md
PADDLE_MOVE_SCHED -- requirements
Module: paddle_move_sched

Interface
- REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1000000, giving the consecutive stable cycles needed to accept a button change (10 ms at 100 MHz).
- REQ-002 SHALL have parameter ACCEL_FRAMES, default 30, giving the held frames before acceleration applies (used only with ACCEL_EN).
- REQ-003 SHALL have port CLK_100MHz, input, 1 bit: sole clock; all logic on its rising edge.
- REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
- REQ-005 SHALL have port btnUp, input, 2 bits: raw asynchronous up buttons; bit i is paddle i.
- REQ-006 SHALL have port btnDown, input, 2 bits: raw asynchronous down buttons; bit i is paddle i.
- REQ-007 SHALL have port frameTick, input, 1 bit: one-cycle pulse, once per video frame.
- REQ-008 SHALL have port pause, input, 1 bit: level; high suppresses all movement.
- REQ-009 SHALL have port moveUp, output, 2 bits: registered step pulses to paddle i's position block.
- REQ-010 SHALL have port moveDown, output, 2 bits: registered step pulses to paddle i's position block.

Function
- REQ-011 SHALL pass each raw button bit through a 2-flop synchronizer before any other use.
- REQ-012 SHALL debounce each synchronized bit with its own counter:
  - the counter clears whenever the synchronized value equals the debounced value;
  - otherwise the counter increments;
  - the debounced value takes the synchronized value on the cycle the counter reaches DEBOUNCE_CYCLES-1, and the counter then clears.
- REQ-013 SHALL run one independent FSM per paddle with states IDLE, MOVE_UP and MOVE_DN.
- REQ-014 SHALL evaluate FSM transitions every cycle from the debounced inputs:
  - up only -> MOVE_UP;
  - down only -> MOVE_DN;
  - neither or both -> IDLE.
- REQ-015 SHALL treat both buttons held on one paddle as a conflict: the FSM goes to IDLE and that paddle issues no pulse.
- REQ-016 SHALL assert moveUp[i] (resp. moveDown[i]) for exactly one cycle, on the cycle after frameTick is sampled high, when paddle i is in MOVE_UP (resp. MOVE_DN) and pause is low on that sampled cycle.
- REQ-017 SHALL never assert moveUp[i] and moveDown[i] in the same cycle.
- REQ-018 SHALL service both paddles independently and in the same cycle; there is no cross-paddle priority.
- REQ-019 SHALL ignore frameTick while pause is high: no pulses are issued, hold counters freeze, and debounce keeps running.
- REQ-020 SHALL drop an in-flight pulse when the FSM changes state on the frameTick cycle; the decision uses the state registered on that cycle.

Reset
- REQ-021 SHALL clear all of the following on the cycle after Reset is sampled high: synchronizers, debounced values, debounce counters, hold counters, FSMs (to IDLE), moveUp (2'b00) and moveDown (2'b00).
- REQ-022 SHALL abort any pending or in-flight pulse when Reset is asserted mid-operation.
- REQ-023 SHALL issue no pulse until a button has again passed the full debounce after Reset is released.

Configuration
- REQ-024 SHALL compile the acceleration feature in only when macro PADDLE_ACCEL_EN is defined.
- REQ-025 With PADDLE_ACCEL_EN defined, SHALL keep a per-paddle hold counter:
  - it counts unpaused frameTicks while in MOVE_UP or MOVE_DN;
  - it saturates at ACCEL_FRAMES;
  - it clears on any state change.
- REQ-026 With PADDLE_ACCEL_EN defined and the hold counter saturated, SHALL issue a second pulse two cycles after the first (frameTick+1 and frameTick+3, one low cycle between them).
- REQ-027 With PADDLE_ACCEL_EN defined, SHALL cancel a pending second pulse if a new frameTick, a state change or pause arrives first.
- REQ-028 Without PADDLE_ACCEL_EN, SHALL contain no hold counter and issue at most one pulse per frameTick per paddle.

Verification
All scenarios use DEBOUNCE_CYCLES=4 and ACCEL_FRAMES=3.
- REQ-029 btnUp[0]=1 held 10 cycles, then frameTick -> moveUp[0]=1 for exactly the cycle after frameTick; moveDown stays 0; paddle 1 outputs stay 0.
- REQ-030 btnDown[1] glitch high for 2 cycles, then frameTick -> no pulse on any output.
- REQ-031 btnUp[0]=btnDown[0]=1 held, then 3 frameTicks -> both outputs stay 0; release btnDown[0] -> moveUp[0] pulses on the next tick.
- REQ-032 pause=1 with btnUp[1] held, then 2 frameTicks -> no pulses; pause=0 -> moveUp[1] pulses on the following tick.
- REQ-033 Reset asserted on the frameTick cycle with btnDown[0] held -> moveDown[0]=0 next cycle, and no pulse until the debounce is re-satisfied.
- REQ-034 With PADDLE_ACCEL_EN, btnUp[0] held over frameTicks 1-4 -> single pulse on ticks 1-3; on tick 4, pulses at tick+1 and tick+3.
